m2vidct_sched: RTL and testbench

- Block scheduler that sequences m2vidct.
- Accepts one macroblock descriptor at a time: block-enable mask, coded block pattern and intra flag.
- Issues one block_start per block when the IDCT reports ready, and drives the s2/s3/s4 side-information pipeline that tracks blocks through coefficient feed, transform and pixel read-out.
- Sits between the VLD/dequant control and m2vidct, and flushes the pipeline at end of picture.

---
 rtl/m2v_idct_pkg.sv | 19 +
 rtl/m2vidct_sidepipe.sv | 53 +++++
 rtl/m2vidct_sched.sv | 143 ++++++++++++++
 tb/tb_m2vidct_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/m2v_idct_pkg.sv
// Shared types for the m2vidct block scheduler: FSM states and per-block side information.
package m2v_idct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    FLUSH = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic enable;
    logic coded;
    logic last;
  } blk_side_t;

  localparam blk_side_t SIDE_BUBBLE = '0;

endpackage

// File: rtl/m2vidct_sidepipe.sv
// Three-stage s2/s3/s4 side-info shift register, advanced only on block_start edges.
// mb_done is high in the cycle after a tagged-last entry has been shifted into s4.
module m2vidct_sidepipe
  import m2v_idct_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_clr,
  input  logic      i_adv,
  input  blk_side_t i_s2_nxt,
  output logic      o_s2_enable,
  output logic      o_s2_coded,
  output logic      o_s3_enable,
  output logic      o_s3_coded,
  output logic      o_s4_enable,
  output logic      o_s4_coded,
  output logic      o_mb_done
);

  blk_side_t r_s2, r_s3, r_s4;
  logic      r_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2  <= SIDE_BUBBLE;
      r_s3  <= SIDE_BUBBLE;
      r_s4  <= SIDE_BUBBLE;
      r_adv <= 1'b0;
    end else if (i_clr) begin
      r_s2  <= SIDE_BUBBLE;
      r_s3  <= SIDE_BUBBLE;
      r_s4  <= SIDE_BUBBLE;
      r_adv <= 1'b0;
    end else begin
      r_adv <= i_adv;
      if (i_adv) begin
        r_s4 <= r_s3;
        r_s3 <= r_s2;
        r_s2 <= i_s2_nxt;
      end
    end
  end

  assign o_s2_enable = r_s2.enable;
  assign o_s2_coded  = r_s2.coded;
  assign o_s3_enable = r_s3.enable;
  assign o_s3_coded  = r_s3.coded;
  assign o_s4_enable = r_s4.enable;
  assign o_s4_coded  = r_s4.coded;
  // Both terms are flops updated on the same edge, so this is a clean one-cycle pulse.
  assign o_mb_done   = r_adv & r_s4.last;

endmodule

// File: rtl/m2vidct_sched.sv
// Macroblock scheduler for m2vidct: one block_start per block (min spacing 2 cycles),
// side-info tracking through s2/s3/s4, and a bubble flush at end of picture.
module m2vidct_sched
  import m2v_idct_pkg::*;
#(
  parameter int BLOCKS = 6,
  parameter int IDXW   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              softreset,
  input  logic              mb_valid,
  output logic              mb_ready,
  input  logic              mb_intra,
  input  logic [BLOCKS-1:0] mb_cbp,
  input  logic [BLOCKS-1:0] mb_blk_en,
  input  logic              flush,
  input  logic              ready_idct,
  output logic              block_start,
  output logic              s2_enable,
  output logic              s2_coded,
  output logic              s3_enable,
  output logic              s3_coded,
  output logic              s4_enable,
  output logic              s4_coded,
  output logic [IDXW-1:0]   blk_index,
  output logic              mb_done,
  output logic              busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCKS - 1);

  sched_state_e      r_state, w_state_nxt;
  logic [IDXW-1:0]   r_blk_cnt, r_blk_index;
  logic [BLOCKS-1:0] r_cbp, r_en;
  logic              r_intra, r_mb_act, r_flushing, r_block_start;
  logic              w_fire, w_last_blk, w_last_issue, w_accept;
  blk_side_t         w_s2_nxt;

  assign w_fire       = ready_idct & ((r_state == ISSUE) | (r_state == FLUSH));
  assign w_last_blk   = (r_blk_cnt == LAST_IDX);
  assign w_last_issue = (r_state == ISSUE) & ready_idct & w_last_blk;
  assign mb_ready     = ((r_state == IDLE) & ~r_flushing) | w_last_issue;
  assign w_accept     = mb_valid & mb_ready;

  // The descriptor is shifted left per issued block, so the MSB is always the current block.
  always_comb begin
    w_s2_nxt = SIDE_BUBBLE;
    if (r_state == ISSUE) begin
      w_s2_nxt.enable = r_en[BLOCKS-1];
      w_s2_nxt.coded  = r_intra | r_cbp[BLOCKS-1];
      w_s2_nxt.last   = w_last_blk;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_state_nxt = ISSUE;
        else if (flush & (s2_enable | s3_enable))
          w_state_nxt = FLUSH;
      end
      ISSUE: if (ready_idct) w_state_nxt = GAP;
      FLUSH: if (ready_idct) w_state_nxt = GAP;
      GAP: begin
        if (r_flushing)
          w_state_nxt = (s2_enable | s3_enable) ? FLUSH : IDLE;
        else
          w_state_nxt = r_mb_act ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_blk_cnt     <= '0;
      r_blk_index   <= '0;
      r_cbp         <= '0;
      r_en          <= '0;
      r_intra       <= 1'b0;
      r_mb_act      <= 1'b0;
      r_flushing    <= 1'b0;
      r_block_start <= 1'b0;
    end else if (softreset) begin
      r_state       <= IDLE;
      r_blk_cnt     <= '0;
      r_blk_index   <= '0;
      r_cbp         <= '0;
      r_en          <= '0;
      r_intra       <= 1'b0;
      r_mb_act      <= 1'b0;
      r_flushing    <= 1'b0;
      r_block_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_block_start <= w_fire;
      r_flushing    <= (w_state_nxt == FLUSH) | (r_flushing & (w_state_nxt == GAP));
      if (w_fire)
        r_blk_index <= (r_state == ISSUE) ? r_blk_cnt : '0;
      // A descriptor accepted on the last issue overrides the end-of-macroblock bookkeeping.
      if (w_accept) begin
        r_intra   <= mb_intra;
        r_cbp     <= mb_cbp;
        r_en      <= mb_blk_en;
        r_blk_cnt <= '0;
        r_mb_act  <= 1'b1;
      end else if (w_fire && (r_state == ISSUE)) begin
        r_cbp <= r_cbp << 1;
        r_en  <= r_en << 1;
        if (w_last_blk) begin
          r_blk_cnt <= '0;
          r_mb_act  <= 1'b0;
        end else begin
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end
      end
    end
  end

  m2vidct_sidepipe u_sidepipe (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_clr       (softreset),
    .i_adv       (w_fire),
    .i_s2_nxt    (w_s2_nxt),
    .o_s2_enable (s2_enable),
    .o_s2_coded  (s2_coded),
    .o_s3_enable (s3_enable),
    .o_s3_coded  (s3_coded),
    .o_s4_enable (s4_enable),
    .o_s4_coded  (s4_coded),
    .o_mb_done   (mb_done)
  );

  assign block_start = r_block_start;
  assign blk_index   = r_blk_index;
  assign busy        = (r_state != IDLE) | s2_enable | s3_enable | s4_enable;

endmodule

// File: tb/tb_m2vidct_sched.sv
// Directed bench for m2vidct_sched: reset, intra/inter macroblocks, flush, stalls,
// back-to-back macroblocks and softreset abort.
module tb_m2vidct_sched;

  localparam int BLOCKS = 6;
  localparam int IDXW   = 4;

  logic              clk = 1'b0;
  logic              reset_n, softreset, mb_valid, mb_intra, flush, ready_idct;
  logic [BLOCKS-1:0] mb_cbp, mb_blk_en;
  logic              mb_ready, block_start, mb_done, busy;
  logic              s2_enable, s2_coded, s3_enable, s3_coded, s4_enable, s4_coded;
  logic [IDXW-1:0]   blk_index;

  int errors = 0;
  int checks = 0;
  int nstarts;
  logic [BLOCKS-1:0] exp_coded;
  logic [BLOCKS-1:0] exp_en;

  always #5 clk = ~clk;

  m2vidct_sched #(.BLOCKS(BLOCKS), .IDXW(IDXW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .softreset   (softreset),
    .mb_valid    (mb_valid),
    .mb_ready    (mb_ready),
    .mb_intra    (mb_intra),
    .mb_cbp      (mb_cbp),
    .mb_blk_en   (mb_blk_en),
    .flush       (flush),
    .ready_idct  (ready_idct),
    .block_start (block_start),
    .s2_enable   (s2_enable),
    .s2_coded    (s2_coded),
    .s3_enable   (s3_enable),
    .s3_coded    (s3_coded),
    .s4_enable   (s4_enable),
    .s4_coded    (s4_coded),
    .blk_index   (blk_index),
    .mb_done     (mb_done),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_mb(input logic intra, input logic [BLOCKS-1:0] cbp,
                         input logic [BLOCKS-1:0] en);
    mb_valid  = 1'b1;
    mb_intra  = intra;
    mb_cbp    = cbp;
    mb_blk_en = en;
  endtask

  initial begin
    reset_n = 1'b0; softreset = 1'b0; mb_valid = 1'b0; mb_intra = 1'b0;
    mb_cbp = '0; mb_blk_en = '0; flush = 1'b0; ready_idct = 1'b0;
    step(); step();

    // 1. reset state
    chk("rst_block_start", block_start, 0);
    chk("rst_side", {s2_enable, s2_coded, s3_enable, s3_coded, s4_enable, s4_coded}, 0);
    chk("rst_blk_index", blk_index, 0);
    chk("rst_mb_done", mb_done, 0);
    chk("rst_mb_ready", mb_ready, 1);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    // 2. intra macroblock, ready_idct held high
    ready_idct = 1'b1;
    send_mb(1'b1, 6'b000000, 6'b111111);
    chk("t2_ready_idle", mb_ready, 1);
    step();
    mb_valid = 1'b0;
    chk("t2_no_start_e0", block_start, 0);
    chk("t2_busy", busy, 1);
    for (int b = 0; b < BLOCKS; b++) begin
      chk($sformatf("t2_mb_ready_b%0d", b), mb_ready, (b == BLOCKS - 1) ? 1 : 0);
      step();
      chk($sformatf("t2_start_b%0d", b), block_start, 1);
      chk($sformatf("t2_index_b%0d", b), blk_index, b);
      chk($sformatf("t2_s2_b%0d", b), {s2_enable, s2_coded}, 2'b11);
      step();
      chk($sformatf("t2_gap_b%0d", b), block_start, 0);
    end

    // 3. inter macroblock, then flush
    send_mb(1'b0, 6'b101000, 6'b111111);
    exp_coded = 6'b101000;
    step();
    mb_valid = 1'b0;
    for (int b = 0; b < BLOCKS; b++) begin
      step();
      chk($sformatf("t3_start_b%0d", b), block_start, 1);
      chk($sformatf("t3_coded_b%0d", b), s2_coded, exp_coded[BLOCKS-1-b]);
      // previous macroblock's block 5 reaches s4 on the second issue
      chk($sformatf("t3_mb_done_b%0d", b), mb_done, (b == 1) ? 1 : 0);
      step();
    end
    flush = 1'b1;
    step();
    step();
    chk("t3_bubble1_start", block_start, 1);
    chk("t3_bubble1_s2", {s2_enable, s2_coded, blk_index}, 0);
    chk("t3_bubble1_s3en", s3_enable, 1);
    chk("t3_bubble1_done", mb_done, 0);
    step();
    step();
    chk("t3_bubble2_start", block_start, 1);
    chk("t3_bubble2_s2s3", {s2_enable, s3_enable}, 0);
    chk("t3_bubble2_s4en", s4_enable, 1);
    chk("t3_bubble2_done", mb_done, 1);
    step();
    chk("t3_done_pulse_end", mb_done, 0);
    step();
    chk("t3_idle_ready", mb_ready, 1);
    step(); step();
    chk("t3_no_third_bubble", block_start, 0);
    flush = 1'b0;

    // 4. ready_idct stall before block 2
    send_mb(1'b1, 6'b000000, 6'b111111);
    step();
    mb_valid = 1'b0;
    step(); step();
    step(); step();
    ready_idct = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      chk($sformatf("t4_stall_start_c%0d", c), block_start, 0);
    end
    chk("t4_stall_index", blk_index, 1);
    chk("t4_stall_side", {s2_enable, s3_enable, s4_enable}, 3'b110);
    ready_idct = 1'b1;
    step();
    chk("t4_resume_start", block_start, 1);
    chk("t4_resume_index", blk_index, 2);
    chk("t4_resume_s4en", s4_enable, 1);
    step();
    for (int b = 3; b < BLOCKS; b++) begin
      step(); step();
    end

    // 5. two macroblocks back-to-back, second has blocks 4,5 absent
    nstarts = 0;
    send_mb(1'b1, 6'b000000, 6'b111111);
    step();
    mb_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      exp_en = (m == 0) ? 6'b111111 : 6'b111100;
      for (int b = 0; b < BLOCKS; b++) begin
        if (m == 0 && b == BLOCKS - 1) begin
          send_mb(1'b1, 6'b000000, 6'b111100);
          chk("t5_last_issue_ready", mb_ready, 1);
        end
        step();
        mb_valid = 1'b0;
        if (block_start) nstarts++;
        chk($sformatf("t5_start_m%0d_b%0d", m, b), block_start, 1);
        chk($sformatf("t5_index_m%0d_b%0d", m, b), blk_index, b);
        chk($sformatf("t5_en_m%0d_b%0d", m, b), s2_enable, exp_en[BLOCKS-1-b]);
        step();
        chk($sformatf("t5_gap_m%0d_b%0d", m, b), block_start, 0);
      end
    end
    chk("t5_total_starts", nstarts, 12);

    // 6. softreset mid-macroblock
    send_mb(1'b1, 6'b000000, 6'b111111);
    step();
    mb_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      step(); step();
    end
    softreset = 1'b1;
    step();
    softreset = 1'b0;
    chk("t6_outputs", {block_start, s2_enable, s2_coded, s3_enable, s3_coded,
                       s4_enable, s4_coded, mb_done}, 0);
    chk("t6_index", blk_index, 0);
    chk("t6_mb_ready", mb_ready, 1);
    chk("t6_busy", busy, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("t6_quiet_c%0d", c), {block_start, mb_done}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
